// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// mips_mem_pkg : shared types and defaults for the unified-memory port arbiter
// Revision     : 1.0
// ============================================================================
package mips_mem_pkg;

  localparam int unsigned C_LAT_DEFAULT        = 2;
  localparam int unsigned C_STARVE_MAX_DEFAULT = 4;
  localparam int unsigned C_CNT_W              = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_e;

  // Wait counter runs LAT-1 .. 0, so the load value is one below the latency.
  function automatic logic [C_CNT_W-1:0] wait_load(input int unsigned lat);
    return C_CNT_W'(lat - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_counter.sv
`default_nettype none
// ============================================================================
// mem_wait_counter : loadable down-counter flagging the final access cycle
// Revision         : 1.0
// ============================================================================
module mem_wait_counter
  import mips_mem_pkg::*;
#(
  parameter int unsigned WIDTH = C_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign last_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one fixed-latency memory between fetch and data
//                    stages, with starvation guard and pipeline stall output
// Revision         : 1.0
// ============================================================================
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LAT        = C_LAT_DEFAULT,
  parameter int unsigned STARVE_MAX = C_STARVE_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,

  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              stall
);

  localparam logic [C_CNT_W-1:0] WAIT_LOAD  = wait_load(LAT);
  localparam logic [C_CNT_W-1:0] STARVE_LIM = C_CNT_W'(STARVE_MAX);

  state_e              state_q;
  gnt_e                gnt_q;
  logic [C_CNT_W-1:0]  starve_cnt_q;
  logic [C_CNT_W-1:0]  starve_cnt_d;

  logic                mem_en_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                if_ack_q;
  logic                dm_ack_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   dm_rdata_q;

  logic                grant_if_d;
  logic                grant_dm_d;
  logic                grant_any_d;
  logic                wait_last;

  // In RESP the requester being acked is excluded, so only the other side can win.
  always_comb begin
    grant_if_d = 1'b0;
    grant_dm_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req && (!dm_req || (starve_cnt_q == STARVE_LIM))) begin
          grant_if_d = 1'b1;
        end else if (dm_req) begin
          grant_dm_d = 1'b1;
        end
      end
      RESP: begin
        if (gnt_q == GNT_DM) begin
          grant_if_d = if_req;
        end else begin
          grant_dm_d = dm_req;
        end
      end
      default: begin
        grant_if_d = 1'b0;
        grant_dm_d = 1'b0;
      end
    endcase
  end

  assign grant_any_d = grant_if_d | grant_dm_d;

  // A fetch being served (ACCESS or RESP with fetch grant) is not losing.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_if_d) begin
      starve_cnt_d = '0;
    end else if (if_req && !((state_q != IDLE) && (gnt_q == GNT_IF)) &&
                 (starve_cnt_q != STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  mem_wait_counter #(
    .WIDTH (C_CNT_W)
  ) u_wait_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (grant_any_d),
    .load_val_i (WAIT_LOAD),
    .dec_i      (state_q == ACCESS),
    .last_o     (wait_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_q        <= GNT_IF;
      starve_cnt_q <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_ack_q     <= 1'b0;
      dm_ack_q     <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      if_ack_q     <= 1'b0;
      dm_ack_q     <= 1'b0;

      case (state_q)
        IDLE, RESP: begin
          if (grant_any_d) begin
            state_q     <= ACCESS;
            gnt_q       <= grant_dm_d ? GNT_DM : GNT_IF;
            mem_en_q    <= 1'b1;
            mem_we_q    <= grant_dm_d & dm_we;
            mem_addr_q  <= grant_dm_d ? dm_addr : if_addr;
            mem_wdata_q <= grant_dm_d ? dm_wdata : '0;
          end else begin
            state_q  <= IDLE;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
          end
        end

        ACCESS: begin
          if (wait_last) begin
            state_q  <= RESP;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (gnt_q == GNT_IF) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= mem_rdata;
            end else begin
              dm_ack_q <= 1'b1;
              if (!mem_we_q) begin
                dm_rdata_q <= mem_rdata;
              end
            end
          end
        end

        default: begin
          state_q  <= IDLE;
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

  assign stall = (if_req & ~if_ack_q) | (dm_req & ~dm_ack_q);

endmodule
`default_nettype wire
